// File: rtl/snake_input_ctrl_if.sv
// Button/command bundle between the input controller and the game core.
// master = controller side (consumes buttons/tick, drives commands); slave = core side.
interface snake_input_ctrl_if;
    logic [5:0] i_buttons;
    logic       i_tick;
    logic [1:0] o_dir;
    logic       o_phase;
    logic       o_restart;
    logic [1:0] o_queue_count;

    modport master (
        input  i_buttons,
        input  i_tick,
        output o_dir,
        output o_phase,
        output o_restart,
        output o_queue_count
    );

    modport slave (
        output i_buttons,
        output i_tick,
        input  o_dir,
        input  o_phase,
        input  o_restart,
        input  o_queue_count
    );
endinterface

// File: rtl/snake_input_ctrl.sv
// Synchronises and debounces the six player buttons, filters direction presses
// against the pending path and feeds a 2-deep turn queue drained by the game tick.
module snake_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    snake_input_ctrl_if.master    bus
);

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);

    logic [5:0]       sync1_q, sync2_q;
    logic [5:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [6];
    logic [CNT_W-1:0] cnt_d [6];
    logic [5:0]       press;

    logic [1:0] dir_q, dir_d;
    logic [1:0] q0_q, q0_d, q1_q, q1_d;
    logic [1:0] count_q, count_d;
    logic       phase_q, phase_d;
    logic       restart_q, restart_d;

    logic       dir_valid;
    logic [1:0] dir_sel;
    logic [1:0] ref_dir;
    logic       push;

    // A level is accepted on the edge its counter would reach the limit.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < 6; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] + 1'b1 == DEB_LIM) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press = stable_d & ~stable_q;
    end

    always_comb begin
        dir_valid = 1'b1;
        dir_sel   = 2'd0;
        if (press[0])      dir_sel = 2'd0;
        else if (press[1]) dir_sel = 2'd1;
        else if (press[2]) dir_sel = 2'd2;
        else if (press[3]) dir_sel = 2'd3;
        else               dir_valid = 1'b0;

        if (count_q == 2'd2)      ref_dir = q1_q;
        else if (count_q == 2'd1) ref_dir = q0_q;
        else                      ref_dir = dir_q;

        // Opposite directions differ only in bit 0 (up/down, left/right).
        push = dir_valid && (dir_sel != ref_dir) && (dir_sel != (ref_dir ^ 2'b01))
               && (count_q != 2'd2);
    end

    always_comb begin
        dir_d     = dir_q;
        q0_d      = q0_q;
        q1_d      = q1_q;
        count_d   = count_q;
        restart_d = 1'b0;
        phase_d   = phase_q ^ press[4];

        if (press[5]) begin
            restart_d = 1'b1;
            count_d   = '0;
            dir_d     = 2'd3;
        end else begin
            if (bus.i_tick && count_q != 2'd0) begin
                dir_d   = q0_q;
                q0_d    = q1_q;
                count_d = count_q - 2'd1;
            end
            // Push lands after any same-cycle pop, keeping FIFO order.
            if (push) begin
                if (count_d == 2'd0) q0_d = dir_sel;
                else                 q1_d = dir_sel;
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            for (int unsigned i = 0; i < 6; i++) cnt_q[i] <= '0;
            dir_q     <= 2'd3;
            q0_q      <= '0;
            q1_q      <= '0;
            count_q   <= '0;
            phase_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            sync1_q   <= bus.i_buttons;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            for (int unsigned i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
            dir_q     <= dir_d;
            q0_q      <= q0_d;
            q1_q      <= q1_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            restart_q <= restart_d;
        end
    end

    assign bus.o_dir         = dir_q;
    assign bus.o_phase       = phase_q;
    assign bus.o_restart     = restart_q;
    assign bus.o_queue_count = count_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed and randomised stimulus for snake_input_ctrl, checked every cycle against a
// window-based debounce and queue model built from the behavioural rules.
module tb_snake_input_ctrl;

    localparam int D = 4;

    logic clk;
    logic rst;

    snake_input_ctrl_if bus ();

    snake_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Model state
    logic [5:0] seen[$];
    logic [5:0] m_stable;
    logic [1:0] mq[$];
    int         m_dir;
    int         m_phase;
    int         m_restart;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        seen.delete();
        for (int i = 0; i < D + 1; i++) seen.push_back(6'd0);
        m_stable  = '0;
        mq.delete();
        m_dir     = 3;
        m_phase   = 0;
        m_restart = 0;
    endtask

    // seen holds the raw samples of the previous D+1 edges; oldest D of them are the
    // synchronised levels seen by the debouncer at this edge.
    task automatic model_step(input logic [5:0] b, input logic t, input logic r);
        logic [5:0] prs;
        int         ref_d, d, pre_n;
        bit         all_diff;
        if (r) begin
            model_reset();
            return;
        end
        prs = '0;
        for (int k = 0; k < 6; k++) begin
            all_diff = 1;
            for (int j = 0; j < D; j++)
                if (seen[j][k] == m_stable[k]) all_diff = 0;
            if (all_diff) begin
                m_stable[k] = ~m_stable[k];
                if (m_stable[k]) prs[k] = 1'b1;
            end
        end
        seen.push_back(b);
        void'(seen.pop_front());

        m_restart = 0;
        if (prs[4]) m_phase = 1 - m_phase;
        pre_n = mq.size();
        ref_d = (pre_n > 0) ? int'(mq[pre_n-1]) : m_dir;
        if (prs[5]) begin
            mq.delete();
            m_dir     = 3;
            m_restart = 1;
        end else begin
            d = -1;
            for (int k = 3; k >= 0; k--) if (prs[k]) d = k;
            if (t && pre_n > 0) m_dir = int'(mq.pop_front());
            if (d >= 0 && d != ref_d && !((d / 2 == ref_d / 2)) && pre_n < 2)
                mq.push_back(2'(d));
        end
    endtask

    task automatic step(input logic [5:0] b, input logic t, input logic r);
        bus.i_buttons = b;
        bus.i_tick    = t;
        rst           = r;
        @(posedge clk);
        model_step(b, t, r);
        @(negedge clk);
        check("dir",     int'(bus.o_dir),         m_dir);
        check("count",   int'(bus.o_queue_count), mq.size());
        check("phase",   int'(bus.o_phase),       m_phase);
        check("restart", int'(bus.o_restart),     m_restart);
    endtask

    task automatic press(input logic [5:0] mask);
        repeat (D + 2) step(mask, 1'b0, 1'b0);
        repeat (D + 3) step(6'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        step(6'd0, 1'b1, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.i_buttons = '0;
        bus.i_tick    = 1'b0;
        rst           = 1'b1;
        model_reset();

        // Reset state
        repeat (2) step(6'd0, 1'b0, 1'b1);
        check("rst_dir",   int'(bus.o_dir), 3);
        check("rst_count", int'(bus.o_queue_count), 0);
        check("rst_phase", int'(bus.o_phase), 0);
        check("rst_pulse", int'(bus.o_restart), 0);

        // Reset with one entry queued
        press(6'b000001);
        check("q1_before_rst", int'(bus.o_queue_count), 1);
        step(6'd0, 1'b0, 1'b1);
        check("q_after_rst", int'(bus.o_queue_count), 0);

        // Glitches, then a held press with exact latency
        for (int i = 0; i < 5; i++) begin
            repeat (3) step(6'b000001, 1'b0, 1'b0);
            step(6'd0, 1'b0, 1'b0);
        end
        repeat (D + 3) step(6'd0, 1'b0, 1'b0);
        check("glitch_count", int'(bus.o_queue_count), 0);
        repeat (5) step(6'b000001, 1'b0, 1'b0);
        check("lat_pre", int'(bus.o_queue_count), 0);
        step(6'b000001, 1'b0, 1'b0);
        check("lat_6", int'(bus.o_queue_count), 1);
        repeat (D + 3) step(6'd0, 1'b0, 1'b0);

        // Reversal / repeat / accept
        step(6'd0, 1'b0, 1'b1);
        press(6'b000100);
        press(6'b001000);
        check("rev_rep", int'(bus.o_queue_count), 0);
        press(6'b000001);
        tick();
        check("t3_dir", int'(bus.o_dir), 0);

        // Full queue drops, drain, empty tick
        step(6'd0, 1'b0, 1'b1);
        press(6'b000001);
        press(6'b000100);
        press(6'b000010);
        check("full", int'(bus.o_queue_count), 2);
        tick();
        tick();
        tick();
        check("t4_dir", int'(bus.o_dir), 2);

        // Simultaneous presses, tick coincident with push
        step(6'd0, 1'b0, 1'b1);
        press(6'b000101);
        check("prio", int'(bus.o_queue_count), 1);
        repeat (D + 1) step(6'b000100, 1'b0, 1'b0);
        step(6'b000100, 1'b1, 1'b0);
        check("tp_dir", int'(bus.o_dir), 0);
        check("tp_cnt", int'(bus.o_queue_count), 1);
        repeat (D + 3) step(6'd0, 1'b0, 1'b0);

        // Restart flush, phase toggling
        press(6'b001000);
        press(6'b000001);
        repeat (D + 1) step(6'b100000, 1'b0, 1'b0);
        step(6'b100000, 1'b0, 1'b0);
        check("rs_pulse", int'(bus.o_restart), 1);
        step(6'b100000, 1'b0, 1'b0);
        check("rs_once", int'(bus.o_restart), 0);
        repeat (D + 3) step(6'd0, 1'b0, 1'b0);
        press(6'b010000);
        check("ph1", int'(bus.o_phase), 1);
        press(6'b010000);
        check("ph0", int'(bus.o_phase), 0);

        // Randomised segments
        for (int s = 0; s < 600; s++) begin
            logic [5:0] m;
            int         hold, sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)      m = 6'(1 << $urandom_range(0, 3));
            else if (sel < 6) m = 6'(1 << $urandom_range(4, 5));
            else if (sel < 8) m = 6'($urandom_range(0, 15));
            else              m = 6'd0;
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++)
                step(m, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
